// File: rtl/mips_isa_pkg.sv
// Shared MIPS-style ISA definitions: opcodes, function codes, field layout
// and legality helpers used by the encoder and the decoder.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_SPECIAL = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Least-significant bit of each field within the 32-bit word
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2,
        FMT_S = 2'd3
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [5:0] op);
        fmt_e f;
        case (op)
            OP_RTYPE:      f = FMT_R;
            OP_J, OP_JAL:  f = FMT_J;
            OP_SPECIAL:    f = FMT_S;
            default:       f = FMT_I;
        endcase
        return f;
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_SPECIAL,
            OP_ADDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic rfunct_is_legal(input logic [5:0] funct);
        logic ok;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry {code,addr} buffer. Head entry always sits in slot0 so the
// output data and both handshake flags come straight from flops.
module enc_fifo2 #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          in_ready
);

    logic [1:0]    count_r;
    logic [1:0]    count_next_s;
    logic [DW-1:0] slot0_r;
    logic [DW-1:0] slot1_r;
    logic          valid_r;
    logic          ready_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s = push & ready_r;
    assign pop_ok_s  = pop & valid_r;

    // Next occupancy; a push with a pop on one entry leaves it at one
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Occupancy, registered flags and slot storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 2'd0;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
            slot0_r <= '0;
            slot1_r <= '0;
        end else begin
            count_r <= count_next_s;
            valid_r <= (count_next_s != 2'd0);
            ready_r <= (count_next_s != 2'd2);
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_r <= push_data;
                    end else begin
                        slot1_r <= push_data;
                    end
                end
                2'b01:   slot0_r <= slot1_r;
                2'b11:   slot0_r <= push_data;
                default: slot0_r <= slot0_r;
            endcase
        end
    end

    assign out_valid = valid_r;
    assign out_data  = slot0_r;
    assign in_ready  = ready_r;

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction field bundles into 32-bit words, tags each legal word with
// its byte address and queues it; illegal bundles are counted and dropped.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [5:0]  in_funct,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_jaddr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_code,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [15:0] word_count,
    output logic [7:0]  err_count
);

    logic [31:0] code_s;
    logic        legal_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] addr_r;
    logic        err_r;
    logic [15:0] word_count_r;
    logic [7:0]  err_count_r;
    logic [63:0] fifo_data_s;

    // Format selection and legality; only the selected format's fields reach code_s
    always_comb begin
        code_s  = 32'h0000_0000;
        legal_s = op_is_legal(in_op);
        case (fmt_of(in_op))
            FMT_R: begin
                code_s = ({26'd0, in_op}    << OP_LSB)
                       | ({27'd0, in_rs}    << RS_LSB)
                       | ({27'd0, in_rt}    << RT_LSB)
                       | ({27'd0, in_rd}    << RD_LSB)
                       | ({27'd0, in_shamt} << SHAMT_LSB)
                       | ({26'd0, in_funct} << FUNCT_LSB);
                legal_s = rfunct_is_legal(in_funct);
            end
            FMT_J: begin
                code_s = ({26'd0, in_op} << OP_LSB) | {6'd0, in_jaddr};
            end
            FMT_S: begin
                code_s = ({26'd0, in_op}    << OP_LSB)
                       | ({27'd0, in_rs}    << RS_LSB)
                       | ({27'd0, in_rt}    << RT_LSB)
                       | ({26'd0, in_funct} << FUNCT_LSB);
            end
            default: begin
                code_s = ({26'd0, in_op} << OP_LSB)
                       | ({27'd0, in_rs} << RS_LSB)
                       | ({27'd0, in_rt} << RT_LSB)
                       | {16'd0, in_imm};
            end
        endcase
    end

    assign accept_s = in_valid & in_ready;
    assign push_s   = accept_s & legal_s;
    assign pop_s    = out_valid & out_ready;

    // Address tag, reject pulse and saturating statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r       <= BASE_ADDR;
            err_r        <= 1'b0;
            err_count_r  <= 8'd0;
            word_count_r <= 16'd0;
        end else begin
            err_r <= accept_s & ~legal_s;
            if (push_s) begin
                addr_r <= addr_r + 32'd4;
            end
            if (accept_s && !legal_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end
            if (pop_s && (word_count_r != 16'hFFFF)) begin
                word_count_r <= word_count_r + 16'd1;
            end
        end
    end

    enc_fifo2 #(
        .DW(64)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data ({code_s, addr_r}),
        .pop       (pop_s),
        .out_valid (out_valid),
        .out_data  (fifo_data_s),
        .in_ready  (in_ready)
    );

    assign out_code   = fifo_data_s[63:32];
    assign out_addr   = fifo_data_s[31:0];
    assign err        = err_r;
    assign err_count  = err_count_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed words, addresses, errors,
// backpressure and reset behaviour.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_jaddr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_code;
    logic [31:0] out_addr;
    logic        err;
    logic [15:0] word_count;
    logic [7:0]  err_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    instr_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_shamt   (in_shamt),
        .in_funct   (in_funct),
        .in_imm     (in_imm),
        .in_jaddr   (in_jaddr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_addr   (out_addr),
        .err        (err),
        .word_count (word_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                              input logic [15:0] imm, input logic [25:0] ja);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_funct = fn; in_imm = imm; in_jaddr = ja;
    endtask

    // Offer one bundle for exactly one edge, then withdraw it
    task automatic send();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_fields(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        #23;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_word_count", {16'd0, word_count}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("ready_low_after_release", {31'd0, in_ready}, 32'd0);
        tick();
        chk("ready_rise", {31'd0, in_ready}, 32'd1);

        // R-type add
        set_fields(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD, 26'h3FFFFFF);
        send();
        chk("r_valid", {31'd0, out_valid}, 32'd1);
        chk("r_code", out_code, 32'h0022_1820);
        chk("r_addr", out_addr, 32'h0000_0000);
        chk("r_err", {31'd0, err}, 32'd0);
        tick();
        chk("r_popped", {31'd0, out_valid}, 32'd0);
        chk("r_word_count", {16'd0, word_count}, 32'd1);

        // I-type addi with junk in unused fields
        set_fields(6'h08, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h2AAAAAA);
        send();
        chk("i_code", out_code, 32'h2022_FFFF);
        chk("i_addr", out_addr, 32'h0000_0004);
        tick();

        // J-type
        set_fields(6'h02, 5'd7, 5'd9, 5'd11, 5'd13, 6'h15, 16'h1234, 26'h0000100);
        send();
        chk("j_code", out_code, 32'h0800_0100);
        chk("j_addr", out_addr, 32'h0000_0008);
        tick();

        // Special format: rd/shamt/imm must not leak in
        set_fields(6'h07, 5'd3, 5'd4, 5'd31, 5'd31, 6'h15, 16'hFFFF, 26'h3FFFFFF);
        send();
        chk("s_code", out_code, 32'h1C64_0015);
        chk("s_addr", out_addr, 32'h0000_000C);
        tick();
        chk("s_word_count", {16'd0, word_count}, 32'd4);

        // Illegal opcode
        set_fields(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0001, 26'd0);
        send();
        chk("ill_err_pulse", {31'd0, err}, 32'd1);
        chk("ill_no_word", {31'd0, out_valid}, 32'd0);
        chk("ill_err_count", {24'd0, err_count}, 32'd1);
        tick();
        chk("ill_err_clear", {31'd0, err}, 32'd0);

        // Illegal R-type funct
        set_fields(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0);
        send();
        chk("fn_err_pulse", {31'd0, err}, 32'd1);
        chk("fn_err_count", {24'd0, err_count}, 32'd2);
        chk("fn_no_word", {31'd0, out_valid}, 32'd0);

        // Legal sw takes the unadvanced address
        set_fields(6'h2B, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0);
        send();
        chk("sw_code", out_code, 32'hACA6_0010);
        chk("sw_addr", out_addr, 32'h0000_0010);
        chk("sw_err", {31'd0, err}, 32'd0);
        tick();
        chk("sw_word_count", {16'd0, word_count}, 32'd5);

        // Fresh reset before the backpressure scenario
        reset = 1'b1;
        #2;
        chk("rst2_word_count", {16'd0, word_count}, 32'd0);
        chk("rst2_err_count", {24'd0, err_count}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Backpressure: three back-to-back ori bundles
        out_ready = 1'b0;
        set_fields(6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0);
        in_valid = 1'b1;
        tick();
        chk("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
        in_imm = 16'h0002;
        tick();
        chk("bp_ready_after_2", {31'd0, in_ready}, 32'd0);
        in_imm = 16'h0003;
        tick();
        chk("bp_hold_code", out_code, 32'h3401_0001);
        chk("bp_hold_addr", out_addr, 32'h0000_0000);
        chk("bp_still_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_w2_code", out_code, 32'h3401_0002);
        chk("bp_w2_addr", out_addr, 32'h0000_0004);
        tick();
        in_valid = 1'b0;
        chk("bp_w3_code", out_code, 32'h3401_0003);
        chk("bp_w3_addr", out_addr, 32'h0000_0008);
        chk("bp_w3_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        chk("bp_word_count", {16'd0, word_count}, 32'd3);

        // Reset with two entries queued
        out_ready = 1'b0;
        set_fields(6'h23, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0008, 26'd0);
        send();
        send();
        chk("mid_full", {31'd0, in_ready}, 32'd0);
        chk("mid_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_word_count", {16'd0, word_count}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_ready_rise", {31'd0, in_ready}, 32'd1);
        chk("mid_empty", {31'd0, out_valid}, 32'd0);
        set_fields(6'h04, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'hFFFE, 26'd0);
        send();
        chk("mid_first_code", out_code, 32'h1021_FFFE);
        chk("mid_first_addr", out_addr, 32'h0000_0000);
        tick();
        chk("mid_word_count", {16'd0, word_count}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one parameter, BASE_ADDR, default 32'h0000_0000, giving the byte address tagged on the first emitted word after reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below (clock and reset first).
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  field bundle present.
- in_ready  out  1  block can accept the bundle this cycle.
- in_op  in  6  opcode.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  function field.
- in_imm  in  16  immediate.
- in_jaddr  in  26  jump target field.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts the word.
- out_code  out  32  encoded instruction word.
- out_addr  out  32  byte address of out_code.
- err  out  1  one-cycle pulse: the accepted bundle was rejected.
- word_count  out  16  words emitted, saturating.
- err_count  out  8  bundles rejected, saturating.

Function
REQ-003 A bundle SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-004 The format SHALL be selected from in_op:
- op==0: R-type {op,rs,rt,rd,shamt,funct}.
- op==2 or 3: J-type {op,jaddr}.
- op==7: special {op,rs,rt,10'b0,funct}.
- all other opcodes: I-type {op,rs,rt,imm}.
REQ-005 Fields unused by the selected format SHALL be ignored and SHALL NOT affect out_code.
REQ-006 The legal opcode set SHALL be {0,2,3,4,7,8,0x0D,0x23,0x2B}; for op==0, the legal funct set SHALL be {0x20,0x22,0x24,0x25,0x2A}.
REQ-007 An accepted illegal bundle SHALL be consumed without producing an output word:
- err SHALL pulse in the next cycle.
- err_count SHALL increment, saturating at 0xFF.
- the address counter SHALL NOT advance.
REQ-008 Each accepted legal bundle SHALL be pushed into a 2-entry FIFO as the pair {code, addr}; addr SHALL then advance by 4, wrapping modulo 2^32.
REQ-009 Latency SHALL be one cycle: a bundle accepted at edge N SHALL make out_valid high after edge N if the FIFO was empty.
REQ-010 in_ready SHALL equal "FIFO not full" and SHALL be registered, with no combinational path from out_ready.
REQ-011 A full FIFO SHALL NOT accept a bundle, even when a pop occurs in the same cycle.
REQ-012 A simultaneous push and pop on a FIFO holding 1 entry SHALL leave the occupancy at 1.
REQ-013 out_code/out_addr SHALL be held stable while out_valid && !out_ready; order SHALL be preserved.
REQ-014 word_count SHALL increment on each out_valid && out_ready, saturating at 0xFFFF.
REQ-015 With the FIFO empty, out_valid SHALL be 0 and out_code/out_addr SHALL be don't-care.

Reset
REQ-016 While reset is high, the block SHALL hold the following values, taking effect asynchronously:
- out_valid=0, in_ready=0, err=0.
- word_count=0, err_count=0.
- FIFO empty; address counter=BASE_ADDR.
REQ-017 Reset asserted mid-operation SHALL discard all FIFO contents; in_ready SHALL rise on the first edge after reset deasserts.

Structure
REQ-018 Opcode constants, funct constants and format-field bit positions SHALL live in a shared package (mips_isa_pkg), also to be used by the decoder.
REQ-019 The 2-entry {code,addr} buffer SHALL be a sub-module named enc_fifo2; encoding and legality checking SHALL be combinational in instr_encoder.

Verification
REQ-020 Legal R-type: op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20 -> out_code=0x00221820, out_addr=0x0, err=0.
REQ-021 Legal I-type: op=8, rs=1, rt=2, imm=0xFFFF, rd=shamt=funct=junk -> out_code=0x2022FFFF.
REQ-022 Legal J-type: op=2, jaddr=0x0000100 -> out_code=0x08000100.
REQ-023 Backpressure: out_ready=0 and 3 bundles offered back-to-back -> in_ready=0 after 2 accepts; once out_ready=1, the bench SHALL see 3 words in order with addrs 0x0, 0x4, 0x8.
REQ-024 Illegal input: op=0x3F, then a legal bundle -> err pulse, err_count=1, no word for the illegal bundle; the legal word SHALL take the unadvanced address.
REQ-025 Reset mid-operation: reset asserted with 2 entries queued -> out_valid=0 immediately, word_count=0; the first word after release SHALL have out_addr=BASE_ADDR.
